adc_delay_train: RTL and testbench

Per-lane input-delay calibration controller for the LTC2145 capture path. While the ADC outputs its alternating test pattern, the block sweeps every delay tap on all data lanes in parallel and scores each tap. It then finds each lane's widest error-free window and loads the window centre into the lane's delay element. It sits beside the per-lane delay/capture cells and drives their tap-load inputs; the system controller starts it and then switches the ADC back to normal data.

---
 rtl/adc_delay_train.sv | 191 +++++++++++++++++++
 tb/tb_adc_delay_train.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_delay_train.sv
// Per-lane input-delay calibration: sweeps every tap on all lanes against the ADC
// alternating test pattern, then loads the centre of each lane's widest clean window.
module adc_delay_train #(
   parameter int LANES       = 8,
   parameter int TAP_W       = 5,
   parameter int SETTLE      = 8,
   parameter int DWELL       = 64,
   parameter int MIN_EYE     = 4,
   parameter int DEFAULT_TAP = 16
) (
   input  logic                         sample_clk,
   input  logic                         reset_n,
   input  logic                         start,
   input  logic [LANES-1:0]             lane_data,
   output logic [LANES-1:0]             delay_ld,
   output logic [LANES*TAP_W-1:0]       delay_val,
   output logic                         busy,
   output logic                         done,
   output logic [LANES-1:0]             fail,
   output logic [LANES*(TAP_W+1)-1:0]   eye_len
);

   // state    | meaning
   // S_IDLE   | waiting for start
   // S_LOAD   | tap t strobed into every delay element
   // S_SETTLE | delay element settling, no scoring
   // S_CHECK  | scoring toggle pattern for DWELL cycles
   // S_UPDATE | fold the tap result into the window trackers
   // S_FINAL  | load window centres (or default) and latch eye_len
   // S_DONE   | one-cycle done pulse
   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_UPDATE, S_FINAL, S_DONE
   } state_t;

   localparam int LEN_W   = TAP_W + 1;
   localparam int CNT_MAX = (SETTLE > DWELL) ? SETTLE : DWELL;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [TAP_W-1:0] T_MAX     = {TAP_W{1'b1}};
   localparam logic [TAP_W-1:0] T_DEFAULT = TAP_W'(DEFAULT_TAP);
   localparam logic [LEN_W-1:0] L_MIN     = LEN_W'(MIN_EYE);
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0] DWELL_LD  = CNT_W'(DWELL - 1);

   state_t             state;
   logic [TAP_W-1:0]   tap;
   logic [CNT_W-1:0]   cnt;
   logic [LANES-1:0]   prev;
   logic [LANES-1:0]   err;

   logic [LEN_W-1:0]   cur_len    [LANES];
   logic [TAP_W-1:0]   cur_start  [LANES];
   logic [LEN_W-1:0]   best_len   [LANES];
   logic [TAP_W-1:0]   best_start [LANES];

   logic [LEN_W-1:0]   nxt_cur_len    [LANES];
   logic [TAP_W-1:0]   nxt_cur_start  [LANES];
   logic [LEN_W-1:0]   nxt_best_len   [LANES];
   logic [TAP_W-1:0]   nxt_best_start [LANES];
   logic [TAP_W-1:0]   fin_tap        [LANES];
   logic [LANES-1:0]   fin_fail;
   logic [TAP_W-1:0]   tap_inc;

   assign tap_inc = tap + TAP_W'(1);

   // Window trackers after this tap's result; the final load is computed from these
   // so the centre taps are strobed in the cycle right after the last UPDATE.
   always_comb begin
      fin_fail = '0;
      for (int i = 0; i < LANES; i++) begin
         nxt_cur_len[i]    = cur_len[i];
         nxt_cur_start[i]  = cur_start[i];
         nxt_best_len[i]   = best_len[i];
         nxt_best_start[i] = best_start[i];
         if (!err[i]) begin
            nxt_cur_len[i]   = cur_len[i] + LEN_W'(1);
            nxt_cur_start[i] = (cur_len[i] == '0) ? tap : cur_start[i];
            if (nxt_cur_len[i] > best_len[i]) begin
               nxt_best_len[i]   = nxt_cur_len[i];
               nxt_best_start[i] = nxt_cur_start[i];
            end
         end else begin
            nxt_cur_len[i] = '0;
         end
         if (nxt_best_len[i] >= L_MIN) begin
            fin_tap[i] = nxt_best_start[i] + TAP_W'(nxt_best_len[i] >> 1);
         end else begin
            fin_tap[i]  = T_DEFAULT;
            fin_fail[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge sample_clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         tap       <= '0;
         cnt       <= '0;
         prev      <= '0;
         err       <= '0;
         delay_ld  <= '0;
         delay_val <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         fail      <= '0;
         eye_len   <= '0;
         for (int i = 0; i < LANES; i++) begin
            cur_len[i]    <= '0;
            cur_start[i]  <= '0;
            best_len[i]   <= '0;
            best_start[i] <= '0;
         end
      end else begin
         prev     <= lane_data;
         delay_ld <= '0;
         done     <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  for (int i = 0; i < LANES; i++) begin
                     cur_len[i]    <= '0;
                     cur_start[i]  <= '0;
                     best_len[i]   <= '0;
                     best_start[i] <= '0;
                  end
                  fail      <= '0;
                  tap       <= '0;
                  busy      <= 1'b1;
                  delay_ld  <= '1;
                  delay_val <= '0;
                  state     <= S_LOAD;
               end
            end
            S_LOAD: begin
               err   <= '0;
               cnt   <= SETTLE_LD;
               state <= S_SETTLE;
            end
            S_SETTLE: begin
               if (cnt == '0) begin
                  cnt   <= DWELL_LD;
                  state <= S_CHECK;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            S_CHECK: begin
               // a lane that failed to toggle since the previous sample is marked bad
               err <= err | ~(lane_data ^ prev);
               if (cnt == '0) begin
                  state <= S_UPDATE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            S_UPDATE: begin
               for (int i = 0; i < LANES; i++) begin
                  cur_len[i]    <= nxt_cur_len[i];
                  cur_start[i]  <= nxt_cur_start[i];
                  best_len[i]   <= nxt_best_len[i];
                  best_start[i] <= nxt_best_start[i];
               end
               delay_ld <= '1;
               if (tap == T_MAX) begin
                  for (int i = 0; i < LANES; i++) begin
                     delay_val[i*TAP_W +: TAP_W] <= fin_tap[i];
                     eye_len[i*LEN_W +: LEN_W]   <= nxt_best_len[i];
                  end
                  fail  <= fin_fail;
                  state <= S_FINAL;
               end else begin
                  for (int i = 0; i < LANES; i++) begin
                     delay_val[i*TAP_W +: TAP_W] <= tap_inc;
                  end
                  tap   <= tap_inc;
                  state <= S_LOAD;
               end
            end
            S_FINAL: begin
               done  <= 1'b1;
               state <= S_DONE;
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_delay_train.sv
// Bench for adc_delay_train: a lane model toggles or holds each lane according to the
// tap it was last loaded with; expected final results are queued and checked at done.
module tb_adc_delay_train;
   localparam int LANES = 8;
   localparam int TAP_W = 5;
   localparam int LW    = TAP_W + 1;
   localparam int CAL_CYC = 2370;
   localparam int LD_CNT  = 33;

   typedef struct packed {
      logic [LANES*TAP_W-1:0] dv;
      logic [LANES-1:0]       fl;
      logic [LANES*LW-1:0]    el;
   } exp_t;

   logic                  sample_clk = 1'b0;
   logic                  reset_n;
   logic                  start = 1'b0;
   logic [LANES-1:0]      lane_data = '0;
   logic [LANES-1:0]      delay_ld;
   logic [LANES*TAP_W-1:0] delay_val;
   logic                  busy;
   logic                  done;
   logic [LANES-1:0]      fail;
   logic [LANES*LW-1:0]   eye_len;

   int checks = 0;
   int errors = 0;
   exp_t q[$];

   adc_delay_train #(
      .LANES(LANES), .TAP_W(TAP_W), .SETTLE(8), .DWELL(64), .MIN_EYE(4), .DEFAULT_TAP(16)
   ) dut (
      .sample_clk(sample_clk), .reset_n(reset_n), .start(start), .lane_data(lane_data),
      .delay_ld(delay_ld), .delay_val(delay_val), .busy(busy), .done(done),
      .fail(fail), .eye_len(eye_len)
   );

   always #5 sample_clk = ~sample_clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Lane model: per-lane pass mask over taps, plus optional one-cycle holds on one lane
   logic [31:0]      pmask [LANES];
   int               hold_lane = -1;
   int               ha_tap = 0, ha_ph = 0, hb_tap = 0, hb_ph = 0;
   logic [TAP_W-1:0] tap_m = '0;
   int               phase = 0;
   logic [LANES-1:0] drv = '0;

   always @(negedge sample_clk) begin : lane_model
      logic h;
      if (delay_ld[0]) begin
         tap_m = delay_val[TAP_W-1:0];
         phase = 0;
      end else begin
         phase++;
      end
      for (int i = 0; i < LANES; i++) begin
         h = !pmask[i][tap_m] ||
             (i == hold_lane && ((int'(tap_m) == ha_tap && phase == ha_ph) ||
                                 (int'(tap_m) == hb_tap && phase == hb_ph)));
         if (!h) drv[i] = ~drv[i];
      end
      lane_data = drv;
   end

   int   cyc = 0, t0 = 0, ld_cnt = 0;
   logic [LANES-1:0] ld_prev = '0;
   bit   busy_chk = 1'b0;

   always @(negedge sample_clk) begin : monitor
      exp_t e;
      cyc++;
      if (busy_chk) begin
         chk("busy_after_done", 64'(busy), 64'd0);
         busy_chk = 1'b0;
      end
      if (start && !busy) begin
         t0     = cyc;
         ld_cnt = 0;
      end
      if (delay_ld != '0) ld_cnt++;
      if (done) begin
         chk("done_expected", 64'(q.size() > 0), 64'd1);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("delay_val", 64'(delay_val), 64'(e.dv));
            chk("fail", 64'(fail), 64'(e.fl));
            chk("eye_len", 64'(eye_len), 64'(e.el));
            chk("latency", 64'(cyc - t0), 64'(CAL_CYC));
            chk("ld_count", 64'(ld_cnt), 64'(LD_CNT));
            chk("final_ld_before_done", 64'(ld_prev), 64'hFF);
         end
         busy_chk = 1'b1;
      end
      ld_prev = delay_ld;
   end

   function automatic exp_t clean_exp();
      exp_t e;
      for (int i = 0; i < LANES; i++) begin
         e.dv[i*TAP_W +: TAP_W] = 5'd16;
         e.el[i*LW +: LW]       = 6'd32;
      end
      e.fl = '0;
      return e;
   endfunction

   task automatic set_lane(inout exp_t e, input int i, input int t, input int len, input bit f);
      e.dv[i*TAP_W +: TAP_W] = TAP_W'(t);
      e.el[i*LW +: LW]       = LW'(len);
      e.fl[i]                = f;
   endtask

   task automatic clean_lanes();
      for (int i = 0; i < LANES; i++) pmask[i] = 32'hFFFF_FFFF;
      hold_lane = -1;
   endtask

   task automatic pulse_start();
      @(posedge sample_clk); #1 start = 1'b1;
      @(posedge sample_clk); #1 start = 1'b0;
   endtask

   task automatic run_cal(input exp_t e, input int mid_start);
      bit seen;
      q.push_back(e);
      pulse_start();
      if (mid_start > 0) begin
         repeat (mid_start) @(posedge sample_clk);
         pulse_start();
      end
      seen = 1'b0;
      for (int n = 0; n < 3000 && !seen; n++) begin
         @(negedge sample_clk);
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=none required=done");
      end
      repeat (5) @(posedge sample_clk);
   endtask

   initial begin
      exp_t e;
      bit   hit;
      int   dcnt;
      clean_lanes();
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      repeat (3) @(posedge sample_clk);
      #1;
      chk("rst_delay_ld", 64'(delay_ld), 64'd0);
      chk("rst_delay_val", 64'(delay_val), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_fail", 64'(fail), 64'd0);
      chk("rst_eye_len", 64'(eye_len), 64'd0);
      reset_n = 1'b1;
      repeat (3) @(posedge sample_clk);

      // all lanes clean
      run_cal(clean_exp(), 0);

      // lane 2 closed outside taps 6..19
      clean_lanes();
      pmask[2] = 32'h000F_FFC0;
      e = clean_exp();
      set_lane(e, 2, 13, 14, 1'b0);
      run_cal(e, 0);

      // lane 0 two equal windows 2..7 and 20..25
      clean_lanes();
      pmask[0] = 32'h03F0_00FC;
      e = clean_exp();
      set_lane(e, 0, 5, 6, 1'b0);
      run_cal(e, 0);

      // lane 5 dead, lane 6 narrow eye 10..12
      clean_lanes();
      pmask[5] = 32'h0000_0000;
      pmask[6] = 32'h0000_1C00;
      e = clean_exp();
      set_lane(e, 5, 16, 0, 1'b1);
      set_lane(e, 6, 16, 3, 1'b1);
      run_cal(e, 0);

      // lane 3: hold in last DWELL cycle of tap 7, hold during SETTLE of tap 24
      clean_lanes();
      hold_lane = 3;
      ha_tap = 7;  ha_ph = 72;
      hb_tap = 24; hb_ph = 4;
      e = clean_exp();
      set_lane(e, 3, 20, 24, 1'b0);
      run_cal(e, 0);

      // start pulse mid-sweep is ignored
      clean_lanes();
      run_cal(clean_exp(), 500);

      // reset asserted at tap 17
      pulse_start();
      hit = 1'b0;
      for (int n = 0; n < 2000 && !hit; n++) begin
         @(negedge sample_clk);
         if (delay_ld[0] && delay_val[TAP_W-1:0] == 5'd17) hit = 1'b1;
      end
      chk("reach_tap17", 64'(hit), 64'd1);
      repeat (20) @(posedge sample_clk);
      #1 reset_n = 1'b0;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_delay_ld", 64'(delay_ld), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      repeat (3) @(posedge sample_clk);
      #1 reset_n = 1'b1;
      dcnt = 0;
      repeat (2500) begin
         @(negedge sample_clk);
         if (done) dcnt++;
      end
      chk("abort_no_done", 64'(dcnt), 64'd0);

      // full calibration after abort
      run_cal(clean_exp(), 0);

      chk("queue_drained", 64'(q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
